// File: rtl/rram_io_bus_ctrl.sv
// RRAM IO word-access sequencer: sense-amp read onto Z_BUS or write-driver pulse,
// with bus turnaround on direction change. Optional overrun flag: RRAM_IO_OVERRUN_FLAG_EN.
module rram_io_bus_ctrl #(
  parameter int unsigned SA_CYC = 3,
  parameter int unsigned WR_CYC = 4,
  parameter int unsigned TA_CYC = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ,
  input  logic WE,
`ifdef RRAM_IO_OVERRUN_FLAG_EN
  input  logic CLR_OVR,
  output logic OVR,
`endif
  output logic BUSY,
  output logic ACK,
  output logic SA_EN,
  output logic OE,
  output logic WR_EN
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TURN  = 3'd1,
    S_SENSE = 3'd2,
    S_DRIVE = 3'd3,
    S_WRITE = 3'd4
  } state_e;

  localparam logic [3:0] SA_LD = 4'(SA_CYC - 1);
  localparam logic [3:0] WR_LD = 4'(WR_CYC - 1);
  localparam logic [3:0] TA_LD = 4'(TA_CYC - 1);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       type_q, type_d;
  logic       last_wr_q, last_wr_d;
  logic       busy_q, busy_d;
  logic       ack_q, ack_d;
  logic       sa_en_q, sa_en_d;
  logic       oe_q, oe_d;
  logic       wr_en_q, wr_en_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    type_d    = type_q;
    last_wr_d = last_wr_q;
    case (state_q)
      S_IDLE: begin
        if (REQ) begin
          type_d = WE;
          if ((WE != last_wr_q) && (TA_CYC != 0)) begin
            state_d = S_TURN;
            cnt_d   = TA_LD;
          end else if (WE) begin
            state_d = S_WRITE;
            cnt_d   = WR_LD;
          end else begin
            state_d = S_SENSE;
            cnt_d   = SA_LD;
          end
        end
      end
      S_TURN: begin
        if (cnt_q == 4'd0) begin
          if (type_q) begin
            state_d = S_WRITE;
            cnt_d   = WR_LD;
          end else begin
            state_d = S_SENSE;
            cnt_d   = SA_LD;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_SENSE: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DRIVE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DRIVE: begin
        state_d   = S_IDLE;
        last_wr_d = 1'b0;
      end
      S_WRITE: begin
        if (cnt_q == 4'd0) begin
          state_d   = S_IDLE;
          last_wr_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they flop in step with it.
  always_comb begin
    busy_d  = (state_d != S_IDLE);
    sa_en_d = (state_d == S_SENSE) || (state_d == S_DRIVE);
    oe_d    = (state_d == S_DRIVE);
    wr_en_d = (state_d == S_WRITE);
    ack_d   = (state_d == S_DRIVE) || ((state_d == S_WRITE) && (cnt_d == 4'd0));
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      type_q    <= 1'b0;
      last_wr_q <= 1'b0;
      busy_q    <= 1'b0;
      ack_q     <= 1'b0;
      sa_en_q   <= 1'b0;
      oe_q      <= 1'b0;
      wr_en_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      type_q    <= type_d;
      last_wr_q <= last_wr_d;
      busy_q    <= busy_d;
      ack_q     <= ack_d;
      sa_en_q   <= sa_en_d;
      oe_q      <= oe_d;
      wr_en_q   <= wr_en_d;
    end
  end

  assign BUSY  = busy_q;
  assign ACK   = ack_q;
  assign SA_EN = sa_en_q;
  assign OE    = oe_q;
  assign WR_EN = wr_en_q;

`ifdef RRAM_IO_OVERRUN_FLAG_EN
  logic ovr_q, ovr_d;

  // A dropped request (busy, not on the ACK cycle) beats a same-cycle clear.
  always_comb begin
    ovr_d = ovr_q;
    if (CLR_OVR) ovr_d = 1'b0;
    if (REQ && busy_q && !ack_q) ovr_d = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) ovr_q <= 1'b0;
    else     ovr_q <= ovr_d;
  end

  assign OVR = ovr_q;
`endif

endmodule

// File: tb/tb_rram_io_bus_ctrl.sv
// Scoreboard bench for rram_io_bus_ctrl: a per-access timeline model fills an
// expectation queue; a negedge monitor compares the output vector every cycle.
module tb_rram_io_bus_ctrl;

  localparam int SA = 3;
  localparam int WR = 4;
  localparam int TA = 1;

  logic CLK = 1'b0;
  logic RST, REQ, WE;
  logic BUSY, ACK, SA_EN, OE, WR_EN;
`ifdef RRAM_IO_OVERRUN_FLAG_EN
  logic CLR_OVR, OVR;
`endif

  rram_io_bus_ctrl #(.SA_CYC(SA), .WR_CYC(WR), .TA_CYC(TA)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WE(WE),
`ifdef RRAM_IO_OVERRUN_FLAG_EN
    .CLR_OVR(CLR_OVR), .OVR(OVR),
`endif
    .BUSY(BUSY), .ACK(ACK), .SA_EN(SA_EN), .OE(OE), .WR_EN(WR_EN)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         cyc;
    logic [4:0] v;   // {BUSY, ACK, SA_EN, OE, WR_EN}
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   free_at = 0;
  logic last_wr = 1'b0;

  always @(posedge CLK) cyc <= cyc + 1;

  // Access timeline built straight from the latency rules.
  task automatic model_accept(input logic w);
    int t;
    t = cyc + 1;
    if (w != last_wr && TA > 0)
      for (int i = 0; i < TA; i++) begin q.push_back('{t, 5'b10000}); t++; end
    if (w) begin
      for (int i = 0; i < WR; i++) begin
        q.push_back('{t, (i == WR - 1) ? 5'b11001 : 5'b10001}); t++;
      end
    end else begin
      for (int i = 0; i < SA; i++) begin q.push_back('{t, 5'b10100}); t++; end
      q.push_back('{t, 5'b11110}); t++;
    end
    free_at = t;
    last_wr = w;
  endtask

  task automatic step(input logic r, input logic w, output bit acc);
    REQ = r;
    WE  = w;
    acc = 1'b0;
    if (r && cyc >= free_at) begin
      acc = 1'b1;
      model_accept(w);
    end
    @(posedge CLK); #1;
  endtask

  task automatic hold_req(input logic w);
    bit a;
    a = 1'b0;
    for (int i = 0; i < 40 && !a; i++) step(1'b1, w, a);
    checks++;
    if (!a) begin failures++; $display("FAIL hold_req not accepted within bound we=%0b", w); end
  endtask

  task automatic idle_wait();
    bit a;
    for (int i = 0; i < 64 && cyc < free_at; i++) step(1'b0, 1'b0, a);
    step(1'b0, 1'b0, a);
  endtask

  task automatic do_reset();
    #2 RST = 1'b1;
    q.delete();
    #1;
    checks++;
    if ({BUSY, ACK, SA_EN, OE, WR_EN} !== 5'b0) begin
      failures++;
      $display("FAIL async_reset outputs got=%b exp=00000", {BUSY, ACK, SA_EN, OE, WR_EN});
    end
    @(posedge CLK); #1;
    RST = 1'b0;
    free_at = cyc;
    last_wr = 1'b0;
  endtask

  // Monitor: compare every cycle against the queued timeline (idle = all zero).
  logic [4:0] e_v, a_v;
`ifdef RRAM_IO_OVERRUN_FLAG_EN
  logic ovr_m = 1'b0;
`endif
  always @(negedge CLK) begin
    e_v = 5'b0;
    while (q.size() > 0 && q[0].cyc < cyc) begin
      checks++; failures++;
      $display("FAIL stale_expect cyc=%0d exp_cyc=%0d", cyc, q[0].cyc);
      void'(q.pop_front());
    end
    if (q.size() > 0 && q[0].cyc == cyc) e_v = q.pop_front().v;
    if (RST) e_v = 5'b0;
    a_v = {BUSY, ACK, SA_EN, OE, WR_EN};
    checks++;
    if (a_v !== e_v) begin
      failures++;
      $display("FAIL trace cyc=%0d got=%b exp=%b", cyc, a_v, e_v);
    end
    checks++;
    if (OE === 1'b1 && WR_EN === 1'b1) begin
      failures++;
      $display("FAIL oe_wr_overlap cyc=%0d got OE=1 WR_EN=1 exp not both", cyc);
    end
`ifdef RRAM_IO_OVERRUN_FLAG_EN
    if (RST) ovr_m = 1'b0;
    checks++;
    if (OVR !== ovr_m) begin
      failures++;
      $display("FAIL ovr cyc=%0d got=%b exp=%b", cyc, OVR, ovr_m);
    end
    ovr_m = RST ? 1'b0 : ((REQ && e_v[4] && !e_v[3]) || (ovr_m && !CLR_OVR));
`endif
  end

  initial begin
    bit a;
    RST = 1'b1; REQ = 1'b0; WE = 1'b0;
`ifdef RRAM_IO_OVERRUN_FLAG_EN
    CLR_OVR = 1'b0;
`endif
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({BUSY, ACK, SA_EN, OE, WR_EN} !== 5'b0) begin
      failures++;
      $display("FAIL reset_state got=%b exp=00000", {BUSY, ACK, SA_EN, OE, WR_EN});
    end
    RST = 1'b0;
    free_at = cyc;
    last_wr = 1'b0;

    // Single read straight out of reset.
    step(1'b1, 1'b0, a);
    idle_wait();

    // Write after reset: turnaround applies.
    do_reset();
    step(1'b1, 1'b1, a);
    idle_wait();

    // REQ held: read, write, read back to back.
    hold_req(1'b0);
    hold_req(1'b1);
    hold_req(1'b0);
    idle_wait();

    // Two consecutive writes, same direction (no TURN between them).
    hold_req(1'b1);
    hold_req(1'b1);
    idle_wait();

    // Reset during the second SENSE cycle, then a normal read.
    step(1'b1, 1'b0, a);
    step(1'b0, 1'b0, a);
    checks++;
    if (SA_EN !== 1'b1) begin
      failures++;
      $display("FAIL sense_before_reset got SA_EN=%b exp=1", SA_EN);
    end
    do_reset();
    step(1'b1, 1'b0, a);
    idle_wait();

`ifdef RRAM_IO_OVERRUN_FLAG_EN
    hold_req(1'b1);
    step(1'b0, 1'b1, a);
    step(1'b1, 1'b1, a);
    step(1'b0, 1'b1, a);
    idle_wait();
    CLR_OVR = 1'b1;
    step(1'b0, 1'b0, a);
    CLR_OVR = 1'b0;
    step(1'b0, 1'b0, a);
`endif

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
`ifdef RRAM_IO_OVERRUN_FLAG_EN
      CLR_OVR = ($urandom_range(0, 7) == 0);
`endif
      step(($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)), a);
    end
`ifdef RRAM_IO_OVERRUN_FLAG_EN
    CLR_OVR = 1'b0;
`endif
    idle_wait();

    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got=%0d pending exp=0", q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
